branch_target_buffer: RTL

Parametrised direct-mapped branch target buffer with saturating-counter direction prediction for the IF stage of the pipelined 16-bit CPU. It generalises the fixed predict-not-taken fetch, where every taken B/BR flushes IF/ID. The block predicts next-PC in the same cycle as fetch. It carries its prediction into ID alongside IF/ID and compares it there against the resolved branch outcome. It raises a one-cycle redirect on mismatch and trains its table.

---
 rtl/branch_target_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating counters; optional stats via BRANCH_TARGET_BUFFER_STATS_EN
module branch_target_buffer #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              stall,
  input  logic              flush,
  input  logic              res_branch,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic [ADDR_W-1:0] res_pc,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       stat_lookups,
  output logic [15:0]       stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];
  logic              r_id_valid;
  logic              r_id_pred_taken;
  logic [ADDR_W-1:0] r_id_pred_target;
  logic [IDX_W-1:0]  w_fidx, w_ridx;
  logic [TAG_W-1:0]  w_ftag, w_rtag;
  logic              w_fhit, w_rhit, w_act, w_miss_t, w_miss_n;
  logic [ADDR_W-1:0] w_pc2;
  logic              w_unused;
  assign w_unused    = ^{fetch_pc[0], res_pc[0]};
  assign w_fidx      = fetch_pc[IDX_W:1];
  assign w_ftag      = fetch_pc[ADDR_W-1:IDX_W+1];
  assign w_ridx      = res_pc[IDX_W:1];
  assign w_rtag      = res_pc[ADDR_W-1:IDX_W+1];
  assign w_fhit      = r_valid[w_fidx] && r_tag[w_fidx] == w_ftag;
  assign w_rhit      = r_valid[w_ridx] && r_tag[w_ridx] == w_rtag;
  assign pred_taken  = w_fhit & r_ctr[w_fidx][CTR_W-1];
  assign pred_target = w_fhit ? r_target[w_fidx] : '0;
  // Resolution in ID: a stalled cycle neither redirects nor trains.
  assign w_act       = r_id_valid & ~stall;
  assign w_pc2       = res_pc + ADDR_W'(2);
  assign w_miss_t    = res_branch & res_taken & ~(r_id_pred_taken & r_id_pred_target == res_target);
  assign w_miss_n    = ~(res_branch & res_taken) & r_id_pred_taken;
  assign mispredict  = w_act & (w_miss_t | w_miss_n);
  assign redirect_pc = (w_act & w_miss_t) ? res_target : w_pc2;
  // Table training at res_pc; the fetch lookup in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= '0;
      end
    end else if (w_act) begin
      if (res_branch && w_rhit) begin
        r_ctr[w_ridx] <= res_taken ? (r_ctr[w_ridx] == CTR_MAX ? CTR_MAX : r_ctr[w_ridx] + CTR_W'(1))
                                   : (r_ctr[w_ridx] == '0 ? '0 : r_ctr[w_ridx] - CTR_W'(1));
        if (res_taken) r_target[w_ridx] <= res_target;
      end else if (res_branch && res_taken) begin
        r_valid[w_ridx]  <= 1'b1;
        r_tag[w_ridx]    <= w_rtag;
        r_target[w_ridx] <= res_target;
        r_ctr[w_ridx]    <= CTR_INIT;
      end else if (!res_branch && r_id_pred_taken) begin
        r_valid[w_ridx] <= 1'b0;
      end
    end
  end
  // Prediction travels with the instruction into ID; flush wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid       <= 1'b0;
      r_id_pred_taken  <= 1'b0;
      r_id_pred_target <= '0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      r_id_valid       <= 1'b1;
      r_id_pred_taken  <= pred_taken;
      r_id_pred_target <= pred_target;
    end
  end
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  logic [15:0] r_stat_lookups, r_stat_mispredicts;
  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (!stall) r_stat_lookups <= r_stat_lookups + 16'd1;
      if (mispredict) r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
    end
  end
  assign stat_lookups     = r_stat_lookups;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif
endmodule
